// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage controller: decodes the EX/MEM instruction, runs the data-memory
// read/write/resp handshake (byte, word, LDI/STI double access, TRAP vector) and stalls until done.
module mem_stage_ctrl #(
  parameter bit SEXT_LDB = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_mem_valid,
  input  logic [3:0]  ex_mem_opcode,
  input  logic [15:0] ex_mem_alu_out,
  input  logic [15:0] ex_mem_sr2real,
  input  logic [15:0] ex_mem_trap_out,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic [15:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_wmask,
  output logic [15:0] mem_wdata,
  output logic [15:0] mem_stage_data,
  output logic        stall
);

  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_LDW  = 4'b0110;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_STW  = 4'b0111;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] data_q, data_d;

  logic        is_ldb, is_ldw, is_stb, is_stw, is_ldi, is_sti, is_trap;
  logic        mem_op, byte_op;
  logic [15:0] acc1_addr;
  logic [7:0]  ldb_byte;
  logic [15:0] ldb_val;

  always_comb begin
    is_ldb  = (ex_mem_opcode == OP_LDB);
    is_ldw  = (ex_mem_opcode == OP_LDW);
    is_stb  = (ex_mem_opcode == OP_STB);
    is_stw  = (ex_mem_opcode == OP_STW);
    is_ldi  = (ex_mem_opcode == OP_LDI);
    is_sti  = (ex_mem_opcode == OP_STI);
    is_trap = (ex_mem_opcode == OP_TRAP);
    mem_op  = ex_mem_valid & (is_ldb | is_ldw | is_stb | is_stw | is_ldi | is_sti | is_trap);
    byte_op = is_ldb | is_stb;

    acc1_addr = is_trap ? ex_mem_trap_out : ex_mem_alu_out;
    if (!byte_op) acc1_addr[0] = 1'b0;

    ldb_byte = ex_mem_alu_out[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    ldb_val  = SEXT_LDB ? {{8{ldb_byte[7]}}, ldb_byte} : {8'h00, ldb_byte};
  end

  // Access states decode the live opcode without gating on ex_mem_valid so that
  // an access in flight always runs to completion even if the instruction is flushed.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    mem_address = 16'h0000;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wmask   = 2'b00;
    mem_wdata   = 16'h0000;
    stall       = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall = mem_op;
        if (mem_op) state_d = ACC1;
      end
      ACC1: begin
        stall       = 1'b1;
        mem_address = acc1_addr;
        if (is_stb) begin
          mem_write = 1'b1;
          mem_wdata = {ex_mem_sr2real[7:0], ex_mem_sr2real[7:0]};
          mem_wmask = ex_mem_alu_out[0] ? 2'b10 : 2'b01;
        end else if (is_stw) begin
          mem_write = 1'b1;
          mem_wdata = ex_mem_sr2real;
          mem_wmask = 2'b11;
        end else begin
          mem_read = 1'b1;
        end
        if (mem_resp) begin
          if (is_ldi | is_sti) begin
            ptr_d   = mem_rdata;
            state_d = ACC2;
          end else begin
            state_d = DONE;
            if (is_ldb)                data_d = ldb_val;
            else if (is_ldw | is_trap) data_d = mem_rdata;
          end
        end
      end
      ACC2: begin
        stall       = 1'b1;
        mem_address = {ptr_q[15:1], 1'b0};
        if (is_sti) begin
          mem_write = 1'b1;
          mem_wdata = ex_mem_sr2real;
          mem_wmask = 2'b11;
        end else begin
          mem_read = 1'b1;
        end
        if (mem_resp) begin
          state_d = DONE;
          if (!is_sti) data_d = mem_rdata;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= 16'h0000;
      data_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  assign mem_stage_data = data_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: expected MEM/WB results are queued at issue and
// popped when the access completes; handshake outputs are checked every cycle.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_mem_valid;
  logic [3:0]  ex_mem_opcode;
  logic [15:0] ex_mem_alu_out, ex_mem_sr2real, ex_mem_trap_out;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic [15:0] mem_address, mem_wdata, mem_stage_data;
  logic        mem_read, mem_write, stall;
  logic [1:0]  mem_wmask;
  // zero-extending twin shares all inputs; only its result is checked
  logic [15:0] z_address, z_wdata, z_data;
  logic        z_read, z_write, z_stall;
  logic [1:0]  z_wmask;

  typedef struct packed { logic [15:0] sx; logic [15:0] zx; } exp_t;
  exp_t sb[$];
  logic [15:0] m_sx, m_zx;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.SEXT_LDB(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .ex_mem_valid(ex_mem_valid), .ex_mem_opcode(ex_mem_opcode),
    .ex_mem_alu_out(ex_mem_alu_out), .ex_mem_sr2real(ex_mem_sr2real), .ex_mem_trap_out(ex_mem_trap_out),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_stage_data(mem_stage_data), .stall(stall));

  mem_stage_ctrl #(.SEXT_LDB(1'b0)) dut_zx (
    .clk(clk), .reset_n(reset_n), .ex_mem_valid(ex_mem_valid), .ex_mem_opcode(ex_mem_opcode),
    .ex_mem_alu_out(ex_mem_alu_out), .ex_mem_sr2real(ex_mem_sr2real), .ex_mem_trap_out(ex_mem_trap_out),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_address(z_address), .mem_read(z_read),
    .mem_write(z_write), .mem_wmask(z_wmask), .mem_wdata(z_wdata),
    .mem_stage_data(z_data), .stall(z_stall));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".stall"}, {15'd0, stall}, 16'd0);
    chk({tag, ".rd"}, {15'd0, mem_read}, 16'd0);
    chk({tag, ".wr"}, {15'd0, mem_write}, 16'd0);
  endtask

  // present an instruction in EX/MEM during IDLE; stall must rise combinationally
  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] alu,
                       input logic [15:0] sr2, input logic [15:0] trap);
    ex_mem_valid = 1'b1; ex_mem_opcode = op; ex_mem_alu_out = alu;
    ex_mem_sr2real = sr2; ex_mem_trap_out = trap;
    sb.push_back('{sx: m_sx, zx: m_zx});
    #1;
    chk({tag, ".issue_stall"}, {15'd0, stall}, 16'd1);
    chk({tag, ".issue_rd"}, {15'd0, mem_read}, 16'd0);
    chk({tag, ".issue_wr"}, {15'd0, mem_write}, 16'd0);
    step();
  endtask

  // one access state: `waits` cycles without resp, then resp with rdata
  task automatic acc(input string tag, input bit wr, input logic [15:0] addr, input logic [1:0] mask,
                     input logic [15:0] wdata, input int waits, input logic [15:0] rdata);
    for (int i = 0; i <= waits; i++) begin
      mem_resp  = (i == waits);
      mem_rdata = (i == waits) ? rdata : 16'hDEAD;
      #1;
      chk({tag, ".stall"}, {15'd0, stall}, 16'd1);
      chk({tag, ".rd"}, {15'd0, mem_read}, {15'd0, ~wr});
      chk({tag, ".wr"}, {15'd0, mem_write}, {15'd0, wr});
      chk({tag, ".addr"}, mem_address, addr);
      chk({tag, ".wmask"}, {14'd0, mem_wmask}, {14'd0, mask});
      chk({tag, ".wdata"}, mem_wdata, wdata);
      step();
    end
    mem_resp  = 1'b0;
    mem_rdata = 16'hDEAD;
  endtask

  // DONE cycle: stall released, result visible, then back to IDLE
  task automatic done(input string tag);
    exp_t e;
    #1;
    chk_idle({tag, ".done"});
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s.sb: got empty queue want entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".data"}, mem_stage_data, e.sx);
      chk({tag, ".data_zx"}, z_data, e.zx);
    end
    ex_mem_valid = 1'b0;
    step();
    #1;
    chk_idle({tag, ".after"});
  endtask

  initial begin
    reset_n = 1'b0; ex_mem_valid = 1'b0; ex_mem_opcode = 4'h0; ex_mem_alu_out = 16'h0;
    ex_mem_sr2real = 16'h0; ex_mem_trap_out = 16'h0; mem_rdata = 16'h0; mem_resp = 1'b0;
    m_sx = 16'h0; m_zx = 16'h0;
    step(); step();
    #1;
    chk_idle("reset");
    chk("reset.addr", mem_address, 16'h0);
    chk("reset.wmask", {14'd0, mem_wmask}, 16'h0);
    chk("reset.wdata", mem_wdata, 16'h0);
    chk("reset.data", mem_stage_data, 16'h0);
    reset_n = 1'b1;
    step();

    // LDW, two wait states: read held 3 cycles, stall 4 cycles
    m_sx = 16'hBEEF; m_zx = 16'hBEEF;
    issue("ldw", 4'b0110, 16'h3002, 16'h0, 16'h0);
    acc("ldw.a1", 1'b0, 16'h3002, 2'b00, 16'h0, 2, 16'hBEEF);
    done("ldw");

    // LDB odd address, high byte 0x80
    m_sx = 16'hFF80; m_zx = 16'h0080;
    issue("ldb_hi", 4'b0010, 16'h3001, 16'h0, 16'h0);
    acc("ldb_hi.a1", 1'b0, 16'h3001, 2'b00, 16'h0, 0, 16'h80AA);
    done("ldb_hi");

    // STB odd / even byte lanes; result unchanged
    issue("stb_hi", 4'b0011, 16'h4001, 16'h1234, 16'h0);
    acc("stb_hi.a1", 1'b1, 16'h4001, 2'b10, 16'h3434, 1, 16'h0);
    done("stb_hi");
    issue("stb_lo", 4'b0011, 16'h4000, 16'hAB56, 16'h0);
    acc("stb_lo.a1", 1'b1, 16'h4000, 2'b01, 16'h5656, 0, 16'h0);
    done("stb_lo");

    // LDB even address, positive byte
    m_sx = 16'h007F; m_zx = 16'h007F;
    issue("ldb_lo", 4'b0010, 16'h3000, 16'h0, 16'h0);
    acc("ldb_lo.a1", 1'b0, 16'h3000, 2'b00, 16'h0, 0, 16'h807F);
    done("ldb_lo");

    // LDW odd address is word-aligned
    m_sx = 16'h1111; m_zx = 16'h1111;
    issue("ldw_odd", 4'b0110, 16'h3003, 16'h0, 16'h0);
    acc("ldw_odd.a1", 1'b0, 16'h3002, 2'b00, 16'h0, 0, 16'h1111);
    done("ldw_odd");

    // STW
    issue("stw", 4'b0111, 16'h4103, 16'hCAFE, 16'h0);
    acc("stw.a1", 1'b1, 16'h4102, 2'b11, 16'hCAFE, 0, 16'h0);
    done("stw");

    // LDI: pointer then data
    m_sx = 16'h0042; m_zx = 16'h0042;
    issue("ldi", 4'b1010, 16'h5000, 16'h0, 16'h0);
    acc("ldi.a1", 1'b0, 16'h5000, 2'b00, 16'h0, 0, 16'h6000);
    acc("ldi.a2", 1'b0, 16'h6000, 2'b00, 16'h0, 1, 16'h0042);
    done("ldi");

    // STI: odd pointer aligned for the write
    issue("sti", 4'b1011, 16'h5002, 16'h9999, 16'h0);
    acc("sti.a1", 1'b0, 16'h5002, 2'b00, 16'h0, 0, 16'h7001);
    acc("sti.a2", 1'b1, 16'h7000, 2'b11, 16'h9999, 0, 16'h0);
    done("sti");

    // TRAP uses trap_out, not alu_out
    m_sx = 16'h0400; m_zx = 16'h0400;
    issue("trap", 4'b1111, 16'h1234, 16'h0, 16'h0025);
    acc("trap.a1", 1'b0, 16'h0024, 2'b00, 16'h0, 0, 16'h0400);
    done("trap");

    // non-memory opcode and invalid memory op: no access, stray resp ignored
    ex_mem_valid = 1'b1; ex_mem_opcode = 4'b0001; mem_resp = 1'b1; mem_rdata = 16'h5555;
    #1; chk_idle("add");
    step(); #1; chk_idle("add2");
    ex_mem_valid = 1'b0; ex_mem_opcode = 4'b0110;
    #1; chk_idle("inval");
    step(); mem_resp = 1'b0; #1;
    chk_idle("inval2");
    chk("inval.data", mem_stage_data, 16'h0400);

    // valid drops mid-access: access still completes
    m_sx = 16'h2222; m_zx = 16'h2222;
    issue("flush", 4'b0110, 16'h2000, 16'h0, 16'h0);
    ex_mem_valid = 1'b0;
    acc("flush.a1", 1'b0, 16'h2000, 2'b00, 16'h0, 1, 16'h2222);
    done("flush");

    // reset during ACC2 of LDI, then a late resp
    issue("rst", 4'b1010, 16'h5000, 16'h0, 16'h0);
    void'(sb.pop_back());
    acc("rst.a1", 1'b0, 16'h5000, 2'b00, 16'h0, 0, 16'h6000);
    reset_n = 1'b0; ex_mem_valid = 1'b0;
    #1; chk("rst.in_acc2_rd", {15'd0, mem_read}, 16'd1);
    step();
    reset_n = 1'b1; mem_resp = 1'b1; mem_rdata = 16'h0042;
    #1;
    chk_idle("rst.after");
    chk("rst.addr", mem_address, 16'h0);
    chk("rst.data", mem_stage_data, 16'h0);
    step(); mem_resp = 1'b0; #1;
    chk_idle("rst.late");
    chk("rst.late_data", mem_stage_data, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
